// File: rtl/frame_slot_scheduler.sv
// Triple-buffer slot manager: hands frame-store slots to a writer and a reader so the
// reader always gets the newest completed frame and the writer never touches the slot being read.
module frame_slot_scheduler #(
  parameter longint unsigned START_ADDR    = 0,
  parameter int unsigned     FRAMES_AMOUNT = 3,
  parameter int unsigned     FRAME_RES_Y   = 1080,
  parameter int unsigned     FRAME_RES_X   = 1920,
  parameter int unsigned     PX_BYTES      = 2,
  parameter int unsigned     ADDR_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_req_i,
  input  logic                  wr_done_i,
  output logic                  wr_gnt_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  input  logic                  rd_req_i,
  output logic                  rd_gnt_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_valid_o,
  output logic                  rd_new_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           abort_cnt_o
);

  if (FRAMES_AMOUNT < 3) begin : g_bad_frames_amount
    $error("frame_slot_scheduler: FRAMES_AMOUNT must be >= 3");
  end

  localparam int              IDX_W       = $clog2(FRAMES_AMOUNT);
  localparam longint unsigned FRAME_BYTES = 64'(FRAME_RES_X) * 64'(FRAME_RES_Y) * 64'(PX_BYTES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {S_FREE, S_WRITING, S_READY, S_READING} slot_st_e;
  typedef enum logic {W_IDLE, W_ACTIVE} wr_st_e;

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input idx_t s);
    return ADDR_WIDTH'(START_ADDR + 64'(s) * FRAME_BYTES);
  endfunction

  slot_st_e              slot_q [FRAMES_AMOUNT];
  slot_st_e              slot_d [FRAMES_AMOUNT];
  wr_st_e                wr_st_q, wr_st_d;
  idx_t                  wr_slot_q, wr_slot_d;
  idx_t                  rd_slot_q, rd_slot_d;
  logic                  rd_held_q, rd_held_d;
  idx_t                  latest_q, latest_d;
  logic                  latest_vld_q, latest_vld_d;
  logic                  wr_gnt_q, wr_gnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_gnt_q, rd_gnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_new_q, rd_new_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [15:0]           abort_cnt_q, abort_cnt_d;
  idx_t                  free_idx;
  logic                  free_found;

  // Events are applied in a fixed order within one cycle: writer done, reader request,
  // writer request. Each stage sees the slot table as already updated by the stages before it.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latches).
    slot_d       = slot_q;
    wr_st_d      = wr_st_q;
    wr_slot_d    = wr_slot_q;
    rd_slot_d    = rd_slot_q;
    rd_held_d    = rd_held_q;
    latest_d     = latest_q;
    latest_vld_d = latest_vld_q;
    wr_gnt_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    rd_gnt_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_valid_d   = rd_valid_q;
    rd_new_d     = rd_new_q;
    drop_cnt_d   = drop_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    free_idx     = '0;
    free_found   = 1'b0;

    if (wr_st_q == W_ACTIVE && wr_done_i) begin
      if (latest_vld_q) begin
        slot_d[latest_q] = S_FREE;
        if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
      end
      slot_d[wr_slot_q] = S_READY;
      latest_d          = wr_slot_q;
      latest_vld_d      = 1'b1;
      wr_st_d           = W_IDLE;
    end

    if (rd_req_i) begin
      rd_gnt_d = 1'b1;
      if (latest_vld_d) begin
        if (rd_held_q) slot_d[rd_slot_q] = S_FREE;
        slot_d[latest_d] = S_READING;
        rd_slot_d        = latest_d;
        rd_held_d        = 1'b1;
        latest_vld_d     = 1'b0;
        rd_addr_d        = slot_addr(latest_d);
        rd_valid_d       = 1'b1;
        rd_new_d         = 1'b1;
      end else if (rd_held_q) begin
        rd_valid_d = 1'b1;
        rd_new_d   = 1'b0;
      end else begin
        rd_addr_d  = ADDR_WIDTH'(START_ADDR);
        rd_valid_d = 1'b0;
        rd_new_d   = 1'b0;
      end
    end

    if (wr_req_i) begin
      if (wr_st_d == W_ACTIVE) begin
        slot_d[wr_slot_q] = S_FREE;
        if (abort_cnt_d != 16'hFFFF) abort_cnt_d = abort_cnt_d + 16'd1;
      end
      for (int i = 0; i < FRAMES_AMOUNT; i++) begin
        if (!free_found && slot_d[i] == S_FREE) begin
          free_idx   = idx_t'(i);
          free_found = 1'b1;
        end
      end
      slot_d[free_idx] = S_WRITING;
      wr_slot_d        = free_idx;
      wr_st_d          = W_ACTIVE;
      wr_gnt_d         = 1'b1;
      wr_addr_d        = slot_addr(free_idx);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the slot table is control state, not storage; it must be reset so no slot looks busy.
      for (int i = 0; i < FRAMES_AMOUNT; i++) slot_q[i] <= S_FREE;
      wr_st_q      <= W_IDLE;
      wr_slot_q    <= '0;
      rd_slot_q    <= '0;
      rd_held_q    <= 1'b0;
      latest_q     <= '0;
      latest_vld_q <= 1'b0;
      wr_gnt_q     <= 1'b0;
      wr_addr_q    <= ADDR_WIDTH'(START_ADDR);
      rd_gnt_q     <= 1'b0;
      rd_addr_q    <= ADDR_WIDTH'(START_ADDR);
      rd_valid_q   <= 1'b0;
      rd_new_q     <= 1'b0;
      drop_cnt_q   <= '0;
      abort_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples the same pre-edge values.
      slot_q       <= slot_d;
      wr_st_q      <= wr_st_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      rd_held_q    <= rd_held_d;
      latest_q     <= latest_d;
      latest_vld_q <= latest_vld_d;
      wr_gnt_q     <= wr_gnt_d;
      wr_addr_q    <= wr_addr_d;
      rd_gnt_q     <= rd_gnt_d;
      rd_addr_q    <= rd_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_new_q     <= rd_new_d;
      drop_cnt_q   <= drop_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign wr_gnt_o    = wr_gnt_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_gnt_o    = rd_gnt_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_new_o    = rd_new_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign abort_cnt_o = abort_cnt_q;

endmodule

// File: tb/tb_frame_slot_scheduler.sv
// Bench for frame_slot_scheduler: directed scenarios on a 3-slot, 16-byte-frame store at 0x1000,
// then random traffic compared against a role-based model (which slot is written/read/latest).
module tb_frame_slot_scheduler;

  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] FB   = 32'd16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0;
  logic        wr_gnt, rd_gnt, rd_valid, rd_new;
  logic [31:0] wr_addr, rd_addr;
  logic [15:0] drop_cnt, abort_cnt;

  int checks = 0;
  int errors = 0;

  // Model: each role holds a slot index or -1.
  int          m_wr, m_rd, m_latest;
  int          m_drop, m_abort;
  logic        m_wr_gnt, m_rd_gnt, m_rd_valid, m_rd_new;
  logic [31:0] m_wr_addr, m_rd_addr;

  frame_slot_scheduler #(
    .START_ADDR(64'h1000), .FRAMES_AMOUNT(3), .FRAME_RES_Y(2), .FRAME_RES_X(4),
    .PX_BYTES(2), .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_req_i(wr_req), .wr_done_i(wr_done), .wr_gnt_o(wr_gnt), .wr_addr_o(wr_addr),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_o(rd_addr), .rd_valid_o(rd_valid),
    .rd_new_o(rd_new), .drop_cnt_o(drop_cnt), .abort_cnt_o(abort_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addr_of(input int s);
    return BASE + 32'(s) * FB;
  endfunction

  task automatic model_reset();
    m_wr = -1; m_rd = -1; m_latest = -1;
    m_drop = 0; m_abort = 0;
    m_wr_gnt = 1'b0; m_rd_gnt = 1'b0; m_rd_valid = 1'b0; m_rd_new = 1'b0;
    m_wr_addr = BASE; m_rd_addr = BASE;
  endtask

  task automatic model_step(input logic wq, input logic wd, input logic rq);
    int pick;
    m_wr_gnt = 1'b0;
    m_rd_gnt = 1'b0;
    if (wd && m_wr >= 0) begin
      if (m_latest >= 0 && m_drop < 65535) m_drop++;
      m_latest = m_wr;
      m_wr = -1;
    end
    if (rq) begin
      m_rd_gnt = 1'b1;
      if (m_latest >= 0) begin
        m_rd = m_latest; m_latest = -1;
        m_rd_addr = addr_of(m_rd); m_rd_valid = 1'b1; m_rd_new = 1'b1;
      end else if (m_rd >= 0) begin
        m_rd_valid = 1'b1; m_rd_new = 1'b0;
      end else begin
        m_rd_addr = BASE; m_rd_valid = 1'b0; m_rd_new = 1'b0;
      end
    end
    if (wq) begin
      if (m_wr >= 0) begin
        if (m_abort < 65535) m_abort++;
        m_wr = -1;
      end
      pick = -1;
      for (int s = 2; s >= 0; s--)
        if (s != m_rd && s != m_latest) pick = s;
      m_wr = pick;
      m_wr_gnt = 1'b1;
      m_wr_addr = addr_of(pick);
    end
  endtask

  task automatic do_cycle(input logic wq, input logic wd, input logic rq);
    @(negedge clk);
    wr_req = wq; wr_done = wd; rd_req = rq;
    model_step(wq, wd, rq);
    @(posedge clk);
    #1;
    wr_req = 1'b0; wr_done = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (wr_gnt !== 1'b0)       begin errors++; $display("FAIL rst_wr_gnt: got %0b want 0", wr_gnt); end
    checks++; if (rd_gnt !== 1'b0)       begin errors++; $display("FAIL rst_rd_gnt: got %0b want 0", rd_gnt); end
    checks++; if (wr_addr !== BASE)      begin errors++; $display("FAIL rst_wr_addr: got %h want %h", wr_addr, BASE); end
    checks++; if (rd_addr !== BASE)      begin errors++; $display("FAIL rst_rd_addr: got %h want %h", rd_addr, BASE); end
    checks++; if (rd_valid !== 1'b0)     begin errors++; $display("FAIL rst_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (rd_new !== 1'b0)       begin errors++; $display("FAIL rst_rd_new: got %0b want 0", rd_new); end
    checks++; if (drop_cnt !== 16'd0)    begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    checks++; if (abort_cnt !== 16'd0)   begin errors++; $display("FAIL rst_abort: got %0d want 0", abort_cnt); end
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (rd_gnt !== 1'b1)       begin errors++; $display("FAIL empty_rd_gnt: got %0b want 1", rd_gnt); end
    checks++; if (rd_valid !== 1'b0)     begin errors++; $display("FAIL empty_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (rd_addr !== BASE)      begin errors++; $display("FAIL empty_rd_addr: got %h want %h", rd_addr, BASE); end
    checks++; if (rd_new !== 1'b0)       begin errors++; $display("FAIL empty_rd_new: got %0b want 0", rd_new); end
    do_cycle(1'b0, 1'b0, 1'b0);
    checks++; if (rd_gnt !== 1'b0)       begin errors++; $display("FAIL rd_gnt_pulse: got %0b want 0", rd_gnt); end
  endtask

  task automatic test_first_frame();
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_gnt !== 1'b1)       begin errors++; $display("FAIL ff_wr_gnt: got %0b want 1", wr_gnt); end
    checks++; if (wr_addr !== 32'h1000)  begin errors++; $display("FAIL ff_wr_addr: got %h want 1000", wr_addr); end
    do_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (wr_gnt !== 1'b0)       begin errors++; $display("FAIL ff_wr_gnt_pulse: got %0b want 0", wr_gnt); end
    checks++; if (wr_addr !== 32'h1000)  begin errors++; $display("FAIL ff_wr_addr_hold: got %h want 1000", wr_addr); end
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (rd_addr !== 32'h1000)  begin errors++; $display("FAIL ff_rd_addr: got %h want 1000", rd_addr); end
    checks++; if (rd_valid !== 1'b1)     begin errors++; $display("FAIL ff_rd_valid: got %0b want 1", rd_valid); end
    checks++; if (rd_new !== 1'b1)       begin errors++; $display("FAIL ff_rd_new: got %0b want 1", rd_new); end
  endtask

  task automatic test_drop();
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_addr !== 32'h1010)  begin errors++; $display("FAIL drop_wr_addr1: got %h want 1010", wr_addr); end
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_addr !== 32'h1020)  begin errors++; $display("FAIL drop_wr_addr2: got %h want 1020", wr_addr); end
    do_cycle(1'b0, 1'b1, 1'b0);
    checks++; if (drop_cnt !== 16'd1)    begin errors++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_addr !== 32'h1010)  begin errors++; $display("FAIL drop_wr_addr3: got %h want 1010", wr_addr); end
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (rd_addr !== 32'h1020)  begin errors++; $display("FAIL drop_rd_addr: got %h want 1020", rd_addr); end
    checks++; if (rd_new !== 1'b1)       begin errors++; $display("FAIL drop_rd_new: got %0b want 1", rd_new); end
  endtask

  task automatic test_repeat();
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (rd_gnt !== 1'b1)       begin errors++; $display("FAIL rep_rd_gnt: got %0b want 1", rd_gnt); end
    checks++; if (rd_addr !== 32'h1020)  begin errors++; $display("FAIL rep_rd_addr: got %h want 1020", rd_addr); end
    checks++; if (rd_new !== 1'b0)       begin errors++; $display("FAIL rep_rd_new: got %0b want 0", rd_new); end
    checks++; if (rd_valid !== 1'b1)     begin errors++; $display("FAIL rep_rd_valid: got %0b want 1", rd_valid); end
    checks++; if (drop_cnt !== 16'd1)    begin errors++; $display("FAIL rep_drop: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_done_with_read();
    do_cycle(1'b0, 1'b1, 1'b1);
    checks++; if (rd_addr !== 32'h1010)  begin errors++; $display("FAIL dwr_rd_addr: got %h want 1010", rd_addr); end
    checks++; if (rd_new !== 1'b1)       begin errors++; $display("FAIL dwr_rd_new: got %0b want 1", rd_new); end
    checks++; if (drop_cnt !== 16'd1)    begin errors++; $display("FAIL dwr_drop: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_abort_reset();
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_addr !== 32'h1000)  begin errors++; $display("FAIL ab_wr_addr1: got %h want 1000", wr_addr); end
    do_cycle(1'b1, 1'b0, 1'b0);
    checks++; if (wr_gnt !== 1'b1)       begin errors++; $display("FAIL ab_wr_gnt: got %0b want 1", wr_gnt); end
    checks++; if (wr_addr !== 32'h1000)  begin errors++; $display("FAIL ab_wr_addr2: got %h want 1000", wr_addr); end
    checks++; if (abort_cnt !== 16'd1)   begin errors++; $display("FAIL ab_abort: got %0d want 1", abort_cnt); end
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_gnt !== 1'b0)       begin errors++; $display("FAIL mrst_wr_gnt: got %0b want 0", wr_gnt); end
    checks++; if (rd_addr !== BASE)      begin errors++; $display("FAIL mrst_rd_addr: got %h want %h", rd_addr, BASE); end
    checks++; if (rd_valid !== 1'b0)     begin errors++; $display("FAIL mrst_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (drop_cnt !== 16'd0)    begin errors++; $display("FAIL mrst_drop: got %0d want 0", drop_cnt); end
    checks++; if (abort_cnt !== 16'd0)   begin errors++; $display("FAIL mrst_abort: got %0d want 0", abort_cnt); end
    @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0);
      checks++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0)
        begin errors++; $display("FAIL post_rst_gnt: got wr=%0b rd=%0b want 0/0", wr_gnt, rd_gnt); end
    end
  endtask

  task automatic test_back_to_back();
    do_cycle(1'b1, 1'b0, 1'b1);
    checks++; if (wr_gnt !== 1'b1 || rd_gnt !== 1'b1)
      begin errors++; $display("FAIL b2b_both_gnt: got wr=%0b rd=%0b want 1/1", wr_gnt, rd_gnt); end
    checks++; if (rd_valid !== 1'b0)     begin errors++; $display("FAIL b2b_valid0: got %0b want 0", rd_valid); end
    do_cycle(1'b0, 1'b1, 1'b1);
    checks++; if (rd_gnt !== 1'b1)       begin errors++; $display("FAIL b2b_rd_gnt2: got %0b want 1", rd_gnt); end
    checks++; if (rd_addr !== 32'h1000 || rd_new !== 1'b1)
      begin errors++; $display("FAIL b2b_rd2: got %h/%0b want 1000/1", rd_addr, rd_new); end
    do_cycle(1'b0, 1'b0, 1'b1);
    checks++; if (rd_gnt !== 1'b1 || rd_new !== 1'b0)
      begin errors++; $display("FAIL b2b_rd3: got gnt=%0b new=%0b want 1/0", rd_gnt, rd_new); end
  endtask

  task automatic test_random();
    logic [31:0] act [8];
    logic [31:0] exp [8];
    string       nm  [8];
    logic        wq, wd, rq;
    nm = '{"wr_gnt", "wr_addr", "rd_gnt", "rd_addr", "rd_valid", "rd_new", "drop_cnt", "abort_cnt"};
    for (int c = 0; c < 400; c++) begin
      wq = ($urandom_range(0, 3) == 0);
      wd = ($urandom_range(0, 2) == 0);
      rq = ($urandom_range(0, 3) == 0);
      do_cycle(wq, wd, rq);
      act = '{32'(wr_gnt), wr_addr, 32'(rd_gnt), rd_addr, 32'(rd_valid), 32'(rd_new),
              32'(drop_cnt), 32'(abort_cnt)};
      exp = '{32'(m_wr_gnt), m_wr_addr, 32'(m_rd_gnt), m_rd_addr, 32'(m_rd_valid), 32'(m_rd_new),
              32'(m_drop), 32'(m_abort)};
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (act[k] !== exp[k]) begin
          errors++;
          $display("FAIL rand_%s cycle %0d: got %h want %h", nm[k], c, act[k], exp[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_drop();
    test_repeat();
    test_done_with_read();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_slot_scheduler.md
Name: frame_slot_scheduler

Overview:
- Single-clock slot manager for the triple-buffered frame store.
- Tells the frame writer and the frame reader which frame slot, and so which base address, each must use.
- Writer never overwrites the slot being read. Reader always gets the newest completed frame, or repeats its current frame when no newer one exists.
- Sits in the control domain beside the write and read DMA engines. Their start/done events are already synchronised to clk_i before reaching this block.

Parameters:
- START_ADDR, 0, byte address of slot 0.
- FRAMES_AMOUNT, 3, number of slots; must be >= 3, elaboration error otherwise.
- FRAME_RES_Y, 1080, lines per frame.
- FRAME_RES_X, 1920, pixels per line.
- PX_BYTES, 2, bytes per pixel.
- ADDR_WIDTH, 32, address width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- wr_req_i  in  1  1-cycle pulse: writer starting a new frame.
- wr_done_i  in  1  1-cycle pulse: writer finished current frame.
- wr_gnt_o  out  1  1-cycle pulse: writer slot allocated.
- wr_addr_o  out  ADDR_WIDTH  writer slot base address.
- rd_req_i  in  1  1-cycle pulse: reader starting a frame; releases its held slot.
- rd_gnt_o  out  1  1-cycle pulse: reader slot assigned.
- rd_addr_o  out  ADDR_WIDTH  reader slot base address.
- rd_valid_o  out  1  reader slot holds a completed frame.
- rd_new_o  out  1  granted frame differs from the previous grant.
- drop_cnt_o  out  16  completed frames overwritten before being read; saturating.
- abort_cnt_o  out  16  writer frames restarted before done; saturating.

Behaviour:
- Constants and address:
  - FRAME_BYTES = FRAME_RES_X*FRAME_RES_Y*PX_BYTES.
  - addr(s) = START_ADDR + s*FRAME_BYTES, truncated to ADDR_WIDTH.
- Per-slot state: FREE, WRITING, READY, READING.
  - Registers: wr_slot, rd_slot, latest (index plus latest_vld).
  - At most one slot is WRITING, at most one READING, at most one READY (the latest).
- Reset (asynchronous assert):
  - All slots FREE, latest_vld=0, both grant pulses 0.
  - Both address outputs = START_ADDR.
  - rd_valid_o=0, rd_new_o=0, both counters 0.
- Writer FSM, W_IDLE / W_ACTIVE:
  - W_IDLE + wr_req_i: pick the lowest-index FREE slot, mark it WRITING. Next cycle: wr_gnt_o=1 and wr_addr_o=addr(slot), go W_ACTIVE.
  - A FREE slot always exists when FRAMES_AMOUNT>=3.
  - W_ACTIVE + wr_done_i: the slot becomes READY and latest. Any previous READY slot becomes FREE and drop_cnt_o increments. Go W_IDLE.
  - W_ACTIVE + wr_req_i (no done): the current slot becomes FREE and abort_cnt_o increments. Re-allocate the lowest FREE slot, which may be the same one; grant next cycle; stay W_ACTIVE.
  - wr_done_i in W_IDLE: ignored.
  - wr_done_i and wr_req_i in the same cycle: done first, then the request.
- Reader, on rd_req_i:
  - If latest_vld: the held READING slot (if any) becomes FREE; latest becomes READING; latest_vld=0; rd_new_o=1; rd_valid_o=1.
  - Else, if a slot is held: keep it; rd_new_o=0; rd_valid_o=1.
  - Else, nothing ever completed: rd_valid_o=0, rd_new_o=0, rd_addr_o=START_ADDR.
  - In every case rd_gnt_o pulses the following cycle.
- Output timing:
  - rd_addr_o, rd_valid_o and rd_new_o update with rd_gnt_o and hold until the next grant.
  - wr_addr_o holds until the next wr_gnt_o.
- Simultaneous events:
  - wr_done_i and rd_req_i in the same cycle: done is processed first, so the reader receives the just-completed frame (rd_new_o=1).
  - Writer and reader grants may pulse in the same cycle.
- Latency: exactly 1 cycle from request to grant. Back-to-back requests on consecutive cycles are each granted.
- Reset mid-operation: everything returns to reset values immediately. Pulses in flight are lost; no grant is issued after deassertion without a new request.
- Counters saturate at 0xFFFF.

Test Plan:
All scenarios use FRAMES_AMOUNT=3, RES 4x2, PX_BYTES=2 (FRAME_BYTES=16), START_ADDR=0x1000.
1. Reset, then rd_req_i -> rd_gnt_o 1 cycle later, rd_valid_o=0, rd_addr_o=0x1000, rd_new_o=0.
2. wr_req_i -> wr_gnt_o next cycle, wr_addr_o=0x1000; wr_done_i; rd_req_i -> rd_addr_o=0x1000, rd_valid_o=1, rd_new_o=1.
3. Reader holds slot0; writer completes two frames -> writer addresses 0x1010 then 0x1020; drop_cnt_o=1; next writer request gets 0x1010; rd_req_i -> rd_addr_o=0x1020, rd_new_o=1.
4. rd_req_i with no new completion -> same rd_addr_o, rd_new_o=0, drop_cnt_o unchanged.
5. wr_done_i and rd_req_i in the same cycle -> reader gets the just-written address, rd_new_o=1; no drop counted.
6. wr_req_i twice without done -> abort_cnt_o=1, the second grant reuses 0x1000; then rst_n_i low mid-frame -> all outputs at reset values within the same cycle, no subsequent grant.
